// File: rtl/bsg_manycore_host_link_mux.sv
// Multiplexes several host request channels onto one manycore io link. Each request is tagged
// with its channel number in the top bits of load_id, and returns are routed back by that tag.
module bsg_manycore_host_link_mux #(
   parameter int unsigned num_host_p            = 2,
   parameter int unsigned packet_width_p        = 128,
   parameter int unsigned return_packet_width_p = 64,
   parameter int unsigned load_id_lsb_p         = 0,
   parameter int unsigned load_id_width_p       = 5,
   parameter int unsigned ret_id_lsb_p          = 0,
   parameter int unsigned max_out_credits_p     = 16,
   localparam int unsigned ch_w   = (num_host_p > 1) ? $clog2(num_host_p) : 1,
   localparam int unsigned cred_w = (max_out_credits_p > 0) ? $clog2(max_out_credits_p + 1) : 1
) (
   input  logic                                      clk_i,
   input  logic                                      reset_i,
   input  logic [num_host_p-1:0]                     host_v_i,
   input  logic [num_host_p-1:0][packet_width_p-1:0] host_pkt_i,
   output logic [num_host_p-1:0]                     host_ready_o,
   output logic [num_host_p-1:0]                     host_ret_v_o,
   output logic [return_packet_width_p-1:0]          host_ret_pkt_o,
   input  logic [num_host_p-1:0]                     host_ret_ready_i,
   output logic                                      link_v_o,
   output logic [packet_width_p-1:0]                 link_pkt_o,
   input  logic                                      link_ready_i,
   input  logic                                      link_ret_v_i,
   input  logic [return_packet_width_p-1:0]          link_ret_pkt_i,
   output logic                                      link_ret_yumi_o,
   output logic [num_host_p-1:0][cred_w-1:0]         credits_o,
   output logic                                      err_o
);

   // The channel tag occupies the most significant ch_w bits of the load_id field.
   localparam int unsigned req_tag_lsb = load_id_lsb_p + load_id_width_p - ch_w;
   localparam int unsigned ret_tag_lsb = ret_id_lsb_p + load_id_width_p - ch_w;
   localparam logic [cred_w-1:0] cred_max = cred_w'(max_out_credits_p);
   localparam logic [ch_w:0] num_host_w = (ch_w+1)'(num_host_p);
   localparam logic [ch_w-1:0] last_ch = ch_w'(num_host_p - 1);

   logic                                   out_v_q, out_v_d;
   logic [packet_width_p-1:0]              out_pkt_q, out_pkt_d;
   logic [ch_w-1:0]                        ptr_q, ptr_d;
   logic [num_host_p-1:0][cred_w-1:0]      credits_q, credits_d;
   logic                                   err_q, err_d;

   logic                    can_load;
   logic                    grant_v;
   logic [num_host_p-1:0]   eligible;
   logic [ch_w-1:0]         winner;
   logic [ch_w:0]           cand;

   logic [ch_w-1:0]         dest;
   logic                    dest_ok;
   logic                    dest_ready;
   logic [num_host_p-1:0]   cred_inc;
   logic [num_host_p-1:0]   cred_dec;

   // Round-robin search starting at ptr_q over channels that are valid and hold a credit.
   always_comb begin
      can_load = ~out_v_q | link_ready_i;
      eligible = '0;
      for (int i = 0; i < int'(num_host_p); i++) begin
         eligible[i] = host_v_i[i] & (credits_q[i] != '0);
      end
      winner  = '0;
      grant_v = 1'b0;
      cand    = '0;
      for (int k = 0; k < int'(num_host_p); k++) begin
         cand = {1'b0, ptr_q} + (ch_w+1)'(k);
         if (cand >= num_host_w) begin
            cand = cand - num_host_w;
         end
         if (!grant_v && eligible[cand[ch_w-1:0]]) begin
            grant_v = 1'b1;
            winner  = cand[ch_w-1:0];
         end
      end
      grant_v = grant_v & can_load & ~reset_i;
   end

   always_comb begin
      host_ready_o = '0;
      for (int i = 0; i < int'(num_host_p); i++) begin
         host_ready_o[i] = grant_v & (winner == ch_w'(i));
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant_v) begin
         ptr_d = (winner == last_ch) ? '0 : winner + ch_w'(1);
      end
   end

   always_comb begin
      out_v_d   = can_load ? grant_v : out_v_q;
      out_pkt_d = out_pkt_q;
      if (grant_v) begin
         out_pkt_d = host_pkt_i[winner];
         out_pkt_d[req_tag_lsb +: ch_w] = winner;
      end
   end

   // Return routing is purely combinational; an out-of-range tag is dropped and flagged.
   always_comb begin
      dest         = link_ret_pkt_i[ret_tag_lsb +: ch_w];
      dest_ok      = 1'b0;
      dest_ready   = 1'b0;
      host_ret_v_o = '0;
      for (int i = 0; i < int'(num_host_p); i++) begin
         if (dest == ch_w'(i)) begin
            dest_ok         = 1'b1;
            dest_ready      = host_ret_ready_i[i];
            host_ret_v_o[i] = link_ret_v_i & ~reset_i;
         end
      end
      link_ret_yumi_o = link_ret_v_i & ~reset_i & (dest_ok ? dest_ready : 1'b1);
      host_ret_pkt_o  = link_ret_pkt_i;
      host_ret_pkt_o[ret_tag_lsb +: ch_w] = '0;
   end

   always_comb begin
      cred_inc = '0;
      cred_dec = '0;
      for (int i = 0; i < int'(num_host_p); i++) begin
         cred_dec[i] = grant_v & (winner == ch_w'(i));
         cred_inc[i] = link_ret_yumi_o & dest_ok & (dest == ch_w'(i));
      end
   end

   // Grant and return on the same channel cancel; a return at full count saturates.
   always_comb begin
      credits_d = credits_q;
      err_d     = err_q;
      if (link_ret_yumi_o && !dest_ok) begin
         err_d = 1'b1;
      end
      for (int i = 0; i < int'(num_host_p); i++) begin
         if (cred_inc[i] && !cred_dec[i]) begin
            if (credits_q[i] == cred_max) begin
               err_d = 1'b1;
            end else begin
               credits_d[i] = credits_q[i] + cred_w'(1);
            end
         end else if (cred_dec[i] && !cred_inc[i]) begin
            credits_d[i] = credits_q[i] - cred_w'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         out_v_q   <= 1'b0;
         out_pkt_q <= '0;
         ptr_q     <= '0;
         credits_q <= {num_host_p{cred_max}};
         err_q     <= 1'b0;
      end else begin
         out_v_q   <= out_v_d;
         out_pkt_q <= out_pkt_d;
         ptr_q     <= ptr_d;
         credits_q <= credits_d;
         err_q     <= err_d;
      end
   end

   assign link_v_o   = out_v_q;
   assign link_pkt_o = out_pkt_q;
   assign credits_o  = credits_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_bsg_manycore_host_link_mux.sv
// Bench for bsg_manycore_host_link_mux: scoreboarded request path, table-driven return routing,
// and directed sequences for arbitration, credits, stall, error and reset behaviour.
module tb_bsg_manycore_host_link_mux;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   reset_i;
   logic [1:0]             host_v_i;
   logic [1:0][127:0]      host_pkt_i;
   logic [1:0]             host_ready_o;
   logic [1:0]             host_ret_v_o;
   logic [63:0]            host_ret_pkt_o;
   logic [1:0]             host_ret_ready_i;
   logic                   link_v_o;
   logic [127:0]           link_pkt_o;
   logic                   link_ready_i;
   logic                   link_ret_v_i;
   logic [63:0]            link_ret_pkt_i;
   logic                   link_ret_yumi_o;
   logic [1:0][4:0]        credits_o;
   logic                   err_o;

   logic [2:0]             host_v3;
   logic [2:0][127:0]      host_pkt3;
   logic [2:0]             host_ready3;
   logic [2:0]             host_ret_v3;
   logic [63:0]            host_ret_pkt3;
   logic [2:0]             host_ret_ready3;
   logic                   link_v3;
   logic [127:0]           link_pkt3;
   logic                   link_ret_v3;
   logic [63:0]            link_ret_pkt3;
   logic                   link_ret_yumi3;
   logic [2:0][4:0]        credits3;
   logic                   err3;

   bsg_manycore_host_link_mux dut (
      .clk_i            (clk),
      .reset_i          (reset_i),
      .host_v_i         (host_v_i),
      .host_pkt_i       (host_pkt_i),
      .host_ready_o     (host_ready_o),
      .host_ret_v_o     (host_ret_v_o),
      .host_ret_pkt_o   (host_ret_pkt_o),
      .host_ret_ready_i (host_ret_ready_i),
      .link_v_o         (link_v_o),
      .link_pkt_o       (link_pkt_o),
      .link_ready_i     (link_ready_i),
      .link_ret_v_i     (link_ret_v_i),
      .link_ret_pkt_i   (link_ret_pkt_i),
      .link_ret_yumi_o  (link_ret_yumi_o),
      .credits_o        (credits_o),
      .err_o            (err_o)
   );

   bsg_manycore_host_link_mux #(.num_host_p(3)) dut3 (
      .clk_i            (clk),
      .reset_i          (reset_i),
      .host_v_i         (host_v3),
      .host_pkt_i       (host_pkt3),
      .host_ready_o     (host_ready3),
      .host_ret_v_o     (host_ret_v3),
      .host_ret_pkt_o   (host_ret_pkt3),
      .host_ret_ready_i (host_ret_ready3),
      .link_v_o         (link_v3),
      .link_pkt_o       (link_pkt3),
      .link_ready_i     (1'b1),
      .link_ret_v_i     (link_ret_v3),
      .link_ret_pkt_i   (link_ret_pkt3),
      .link_ret_yumi_o  (link_ret_yumi3),
      .credits_o        (credits3),
      .err_o            (err3)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic rand_pkts();
      for (int c = 0; c < 2; c++) begin
         host_pkt_i[c] = rand128() & ~128'h10;
      end
   endtask

   // Scoreboard: expected link packets pushed on host acceptance, popped on link handshake.
   logic [127:0] exp_q[$];
   logic [127:0] mp;
   always @(negedge clk) begin
      if (reset_i) begin
         exp_q.delete();
      end else begin
         check("one_grant_max", 128'($countones(host_ready_o) <= 1), 128'd1);
         if (link_v_o && link_ready_i) begin
            check("sb_has_entry", 128'(exp_q.size()), 128'd1);
            if (exp_q.size() > 0) check("link_pkt", link_pkt_o, exp_q.pop_front());
         end
         for (int c = 0; c < 2; c++) begin
            if (host_v_i[c] && host_ready_o[c]) begin
               mp    = host_pkt_i[c];
               mp[4] = c[0];
               exp_q.push_back(mp);
            end
         end
      end
   end

   typedef struct {
      logic       v;
      logic       dest;
      logic [1:0] rdy;
      logic [1:0] exp_v;
      logic       exp_yumi;
      int         exp_c0;
      int         exp_c1;
   } ret_vec_t;

   ret_vec_t     tbl[8];
   int           grants;
   logic [127:0] held;
   logic [63:0]  rp;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 12, 1};
      tbl[1] = '{1'b1, 1'b0, 2'b11, 2'b01, 1'b1, 13, 1};
      tbl[2] = '{1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 13, 1};
      tbl[3] = '{1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 13, 1};
      tbl[4] = '{1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 13, 2};
      tbl[5] = '{1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 13, 2};
      tbl[6] = '{1'b1, 1'b0, 2'b01, 2'b01, 1'b1, 14, 2};
      tbl[7] = '{1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 14, 2};

      reset_i = 1'b1; host_v_i = 2'b11; rand_pkts(); host_ret_ready_i = 2'b00;
      link_ready_i = 1'b1; link_ret_v_i = 1'b0; link_ret_pkt_i = '0;
      host_v3 = '0; host_pkt3 = '0; host_ret_ready3 = '0; link_ret_v3 = 1'b0; link_ret_pkt3 = '0;

      // No grant while reset is held, even with requests pending.
      repeat (2) tick();
      @(negedge clk);
      check("rst_no_grant", host_ready_o, 0);
      check("rst_link_v", link_v_o, 0);
      tick(); host_v_i = 2'b00; reset_i = 1'b0;
      @(negedge clk);
      check("reset_link_v", link_v_o, 0);
      check("reset_ready", host_ready_o, 0);
      check("reset_ret_v", host_ret_v_o, 0);
      check("reset_yumi", link_ret_yumi_o, 0);
      check("reset_cred0", credits_o[0], 16);
      check("reset_cred1", credits_o[1], 16);
      check("reset_err", err_o, 0);

      // Two channels streaming: grants alternate, link busy every cycle after the first.
      tick(); host_v_i = 2'b11; rand_pkts();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("rr_alternate", host_ready_o, (i % 2 == 0) ? 2'b01 : 2'b10);
         if (i > 0) check("stream_link_v", link_v_o, 1);
         tick(); rand_pkts();
      end
      host_v_i = 2'b00;
      @(negedge clk);
      tick();
      @(negedge clk);
      check("stream_cred0", credits_o[0], 12);
      check("stream_cred1", credits_o[1], 12);
      check("stream_drained", link_v_o, 0);

      // Link stalled five cycles: one grant, output held steady.
      tick(); link_ready_i = 1'b0; host_v_i = 2'b11; grants = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         grants += $countones(host_ready_o);
         if (i == 1) held = link_pkt_o;
         if (i >= 1) check("stall_link_v", link_v_o, 1);
         if (i >= 2) check("stall_pkt_stable", link_pkt_o, held);
         tick();
      end
      link_ready_i = 1'b1; host_v_i = 2'b00;
      check("stall_grants", grants, 1);
      @(negedge clk);
      tick();
      @(negedge clk);
      check("stall_drained", link_v_o, 0);

      // Channel 1 exhausts its 16 credits, then one return restores one.
      tick(); reset_i = 1'b1;
      tick(); reset_i = 1'b0; host_v_i = 2'b10; grants = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (host_ready_o[1]) grants++;
         if (i >= 16) begin
            check("ch1_starved_ready", host_ready_o[1], 0);
            check("ch1_starved_cred", credits_o[1], 0);
         end
         tick(); rand_pkts();
      end
      host_v_i = 2'b00;
      check("ch1_grants", grants, 16);
      rp = {$urandom, $urandom}; rp[4] = 1'b1;
      link_ret_v_i = 1'b1; link_ret_pkt_i = rp; host_ret_ready_i = 2'b10;
      @(negedge clk);
      check("ret1_v", host_ret_v_o, 2'b10);
      check("ret1_yumi", link_ret_yumi_o, 1);
      check("ret1_pkt", host_ret_pkt_o, rp & ~64'h10);
      tick(); link_ret_v_i = 1'b0;
      @(negedge clk);
      check("ret1_cred", credits_o[1], 1);
      check("ret1_err", err_o, 0);

      // Spend four channel-0 credits so the table returns never overflow.
      tick(); host_v_i = 2'b01;
      repeat (4) begin
         @(negedge clk);
         tick();
      end
      host_v_i = 2'b00;
      @(negedge clk);
      check("spend_cred0", credits_o[0], 12);

      for (int r = 0; r < 8; r++) begin
         tick();
         rp = {$urandom, $urandom}; rp[4] = tbl[r].dest;
         link_ret_v_i = tbl[r].v; link_ret_pkt_i = rp; host_ret_ready_i = tbl[r].rdy;
         @(negedge clk);
         check($sformatf("tbl%0d_ret_v", r), host_ret_v_o, tbl[r].exp_v);
         check($sformatf("tbl%0d_yumi", r), link_ret_yumi_o, tbl[r].exp_yumi);
         if (tbl[r].v) check($sformatf("tbl%0d_pkt", r), host_ret_pkt_o, rp & ~64'h10);
         tick(); link_ret_v_i = 1'b0;
         @(negedge clk);
         check($sformatf("tbl%0d_cred0", r), credits_o[0], tbl[r].exp_c0);
         check($sformatf("tbl%0d_cred1", r), credits_o[1], tbl[r].exp_c1);
         check($sformatf("tbl%0d_err", r), err_o, 0);
      end

      // Grant and return on channel 1 in the same cycle leave its count unchanged.
      tick(); host_v_i = 2'b10;
      rp = {$urandom, $urandom}; rp[4] = 1'b1;
      link_ret_v_i = 1'b1; link_ret_pkt_i = rp; host_ret_ready_i = 2'b10;
      @(negedge clk);
      check("same_grant", host_ready_o, 2'b10);
      check("same_yumi", link_ret_yumi_o, 1);
      tick(); host_v_i = 2'b00; link_ret_v_i = 1'b0;
      @(negedge clk);
      check("same_cred1", credits_o[1], 2);

      // Returns into a full count saturate and raise the error flag.
      tick(); rp = {$urandom, $urandom}; rp[4] = 1'b0;
      link_ret_v_i = 1'b1; link_ret_pkt_i = rp; host_ret_ready_i = 2'b01;
      tick();
      tick(); link_ret_v_i = 1'b0;
      @(negedge clk);
      check("fill_cred0", credits_o[0], 16);
      check("fill_err", err_o, 0);
      tick(); link_ret_v_i = 1'b1;
      tick(); link_ret_v_i = 1'b0;
      @(negedge clk);
      check("ovf_cred0", credits_o[0], 16);
      check("ovf_err", err_o, 1);

      // Reset with a stalled packet and spent credit discards it and restores everything.
      tick(); link_ready_i = 1'b0; host_v_i = 2'b01;
      @(negedge clk);
      check("pre_rst_grant", host_ready_o, 2'b01);
      tick(); host_v_i = 2'b00;
      @(negedge clk);
      check("pre_rst_link_v", link_v_o, 1);
      check("pre_rst_cred0", credits_o[0], 15);
      tick(); reset_i = 1'b1;
      @(negedge clk);
      tick(); reset_i = 1'b0; link_ready_i = 1'b1;
      @(negedge clk);
      check("post_rst_link_v", link_v_o, 0);
      check("post_rst_cred0", credits_o[0], 16);
      check("post_rst_cred1", credits_o[1], 16);
      check("post_rst_err", err_o, 0);
      tick(); host_v_i = 2'b11;
      @(negedge clk);
      check("post_rst_ptr", host_ready_o, 2'b01);
      tick(); host_v_i = 2'b00;
      @(negedge clk);

      // Three-channel instance: tag 2 routes, tag 3 is dropped with a sticky error.
      tick(); rp = {$urandom, $urandom}; rp[4:3] = 2'd2;
      link_ret_v3 = 1'b1; link_ret_pkt3 = rp; host_ret_ready3 = 3'b011;
      @(negedge clk);
      check("n3_dest2_v", host_ret_v3, 3'b100);
      check("n3_dest2_yumi", link_ret_yumi3, 0);
      check("n3_dest2_err", err3, 0);
      tick(); rp[4:3] = 2'd3; link_ret_pkt3 = rp; host_ret_ready3 = 3'b111;
      @(negedge clk);
      check("n3_dest3_v", host_ret_v3, 3'b000);
      check("n3_dest3_yumi", link_ret_yumi3, 1);
      tick(); link_ret_v3 = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("n3_err_sticky", err3, 1);
         tick();
      end
      reset_i = 1'b1;
      tick(); reset_i = 1'b0;
      @(negedge clk);
      check("n3_err_cleared", err3, 0);

      tick();
      @(negedge clk);
      check("sb_drained", 128'(exp_q.size()), 128'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bsg_manycore_host_link_mux.md
BSG_MANYCORE_HOST_LINK_MUX -- requirements
Module: bsg_manycore_host_link_mux

Interface
- REQ-001 SHALL have parameter num_host_p, default 2: number of host channels (1..8) sharing one manycore io link.
- REQ-002 SHALL have parameter packet_width_p, default 128: request packet width.
- REQ-003 SHALL have parameter return_packet_width_p, default 64: return packet width.
- REQ-004 SHALL have parameters load_id_lsb_p (default 0) and load_id_width_p (default 5): bit position and width of load_id in request packets.
- REQ-005 SHALL have parameters ret_id_lsb_p (default 0): bit position of load_id in return packets.
- REQ-006 SHALL have parameter max_out_credits_p, default 16: outstanding requests allowed per channel; derived ch_w=`BSG_SAFE_CLOG2(num_host_p), cred_w=`BSG_SAFE_CLOG2(max_out_credits_p+1).
- REQ-007 SHALL have ports, clock and reset first:
  clk_i  in  1  clock; one clock domain
  reset_i  in  1  synchronous, active-high reset
  host_v_i  in  num_host_p  per-channel request valid
  host_pkt_i  in  num_host_p x packet_width_p  per-channel request
  host_ready_o  out  num_host_p  request accepted this cycle (valid-ready)
  host_ret_v_o  out  num_host_p  per-channel return valid
  host_ret_pkt_o  out  return_packet_width_p  return packet, shared by all channels
  host_ret_ready_i  in  num_host_p  per-channel return ready
  link_v_o  out  1  request to io link valid
  link_pkt_o  out  packet_width_p  request to io link
  link_ready_i  in  1  io link ready
  link_ret_v_i  in  1  return from io link valid
  link_ret_pkt_i  in  return_packet_width_p  return from io link
  link_ret_yumi_o  out  1  return consumed
  credits_o  out  num_host_p x cred_w  remaining credits per channel
  err_o  out  1  sticky misrouted-return flag

Function
- REQ-008 SHALL register link_pkt_o/link_v_o in a one-entry output register; register loads when empty or when link_v_o&link_ready_i in the same cycle.
- REQ-009 SHALL arbitrate round-robin among channels with host_v_i=1 and credits_o>0; grant only when the output register can load; at most one host_ready_o high per cycle.
- REQ-010 SHALL advance the RR pointer to winner+1 (mod num_host_p) after each grant; pointer holds when there is no grant.
- REQ-011 SHALL, on grant, write the channel index into the top ch_w bits of the load_id field; all other bits pass unchanged; request latency host accept at cycle t -> link_v_o at t+1.
- REQ-012 SHALL require hosts to drive the top ch_w load_id bits to zero; the mux restores them to zero on return.
- REQ-013 SHALL route a return to the channel dest = top ch_w bits of the return load_id; host_ret_v_o[dest]=link_ret_v_i, combinational, zero latency; link_ret_yumi_o=link_ret_v_i&host_ret_ready_i[dest].
- REQ-014 SHALL, if dest>=num_host_p, assert link_ret_yumi_o (drop), raise no host_ret_v_o, and set err_o until reset.
- REQ-015 SHALL decrement credits of the granted channel on grant and increment credits of dest on link_ret_yumi_o; on the same channel in the same cycle, count is unchanged.
- REQ-016 SHALL never let a credit underflow below 0 or exceed max_out_credits_p; a return arriving at a full credit count saturates and sets err_o.
- REQ-017 SHALL, when num_host_p=1, degrade to a single registered pass-through with ch_w=1 and the tag bit forced to 0.

Reset
- REQ-018 SHALL, while reset_i=1 at a clock edge: link_v_o=0, host_ready_o=0, link_ret_yumi_o=0, host_ret_v_o=0, RR pointer=0, every credits_o=max_out_credits_p, err_o=0; a pending output-register packet is discarded.
- REQ-019 SHALL accept no request in the first cycle after reset deassertion unless host_v_i is high; no request is granted during reset.

Verification
- REQ-020 Ch0 and ch1 valid continuously with link_ready_i=1 -> grants alternate 0,1,0,1; link_v_o high every cycle from cycle 2.
- REQ-021 Ch1 issues 16 requests with no returns -> credits_o[1]=0, host_ready_o[1]=0 thereafter; one return with dest=1 -> credits_o[1]=1 the next cycle.
- REQ-022 link_ready_i=0 for 5 cycles with all channels valid -> link_pkt_o stable; exactly one grant total; nothing lost when ready rises.
- REQ-023 Return with dest=1 and host_ret_ready_i[1]=0 -> link_ret_yumi_o=0 until ready rises; restored load_id top bits=0.
- REQ-024 num_host_p=3, return with dest=3 -> consumed, no host_ret_v_o, err_o=1 until reset_i.
- REQ-025 Assert reset_i with output register full and credits spent -> next cycle link_v_o=0, credits=max_out_credits_p, pointer=0.
